// File: rtl/serial_adder_ctrl_pkg.sv
// Shared FSM encoding for the bit-serial adder controller.
package serial_adder_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_CALC = ST_CALC,
        S_DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// Single-bit full-adder cell (FA_rtl), time-shared by the serial adder controller.
module FA_rtl (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one FA cell iterated over NBITS cycles, val/rdy on both sides.
// Optional macro SERIAL_ADDER_CTRL_OVERLAP_EN lets a new operand pair load in the same cycle a result leaves.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [NBITS-1:0] in_a,
    input  logic [NBITS-1:0] in_b,
    input  logic             in_cin,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [NBITS-1:0] out_sum,
    output logic             out_cout,
    output state_e           dbg_state_o
);

    localparam int CNT_W = $clog2(NBITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBITS - 1);

    state_e           state_q, state_d;
    logic [NBITS-1:0] a_q, a_d;
    logic [NBITS-1:0] b_q, b_d;
    logic [NBITS-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fa_sum, fa_cout;
    logic             load;

    FA_rtl u_fa (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .cin_i  (carry_q),
        .sum_o  (fa_sum),
        .cout_o (fa_cout)
    );

    // Handshake: a transfer happens on a rising edge where val && rdy are both high.
`ifdef SERIAL_ADDER_CTRL_OVERLAP_EN
    assign in_rdy = ((state_q == S_IDLE) || ((state_q == S_DONE) && out_rdy)) && !reset;
`else
    assign in_rdy = (state_q == S_IDLE) && !reset;
`endif
    assign out_val     = (state_q == S_DONE);
    assign out_sum     = sum_q;
    assign out_cout    = carry_q;
    assign dbg_state_o = state_q;
    assign load        = in_val && in_rdy;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: ;
            S_CALC: begin
                sum_d   = {fa_sum, sum_q[NBITS-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_rdy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // in_rdy is only high in IDLE, or in DONE with the result leaving, so loading wins here.
        if (load) begin
            a_d     = in_a;
            b_d     = in_b;
            carry_d = in_cin;
            cnt_d   = '0;
            state_d = S_CALC;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: vector table, scoreboard monitor and multi-cycle corner sequences.
module tb_serial_adder_ctrl;
    import serial_adder_ctrl_pkg::*;

    localparam int NBITS = 8;
`ifdef SERIAL_ADDER_CTRL_OVERLAP_EN
    localparam int SPACING = NBITS + 1;
`else
    localparam int SPACING = NBITS + 2;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_val = 1'b0;
    logic             in_rdy;
    logic [NBITS-1:0] in_a = '0;
    logic [NBITS-1:0] in_b = '0;
    logic             in_cin = 1'b0;
    logic             out_val;
    logic             out_rdy = 1'b0;
    logic [NBITS-1:0] out_sum;
    logic             out_cout;
    state_e           dbg_state;

    serial_adder_ctrl #(.NBITS(NBITS)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_val      (in_val),
        .in_rdy      (in_rdy),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_cin      (in_cin),
        .out_val     (out_val),
        .out_rdy     (out_rdy),
        .out_sum     (out_sum),
        .out_cout    (out_cout),
        .dbg_state_o (dbg_state)
    );

    // Clock / cycle count
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    int last_xfer = 0;
    int rise_edges[$];
    logic [NBITS:0] exp_q[$];
    bit prev_val = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            prev_val = 1'b0;
        end else begin
            if (out_val && !prev_val) begin
                rise_edges.push_back(cyc);
                check("latency", 64'(cyc - last_xfer), 64'(NBITS));
            end
            if (out_val && out_rdy) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: got 0x%0h expected no result", {out_cout, out_sum});
                end else begin
                    check("sb_result", 64'({out_cout, out_sum}), 64'(exp_q.pop_front()));
                end
            end
            if (in_val && in_rdy) begin
                exp_q.push_back({1'b0, in_a} + {1'b0, in_b} + (NBITS+1)'(in_cin));
                last_xfer = cyc + 1;
            end
            prev_val = out_val;
        end
    end

    // Driver: call at posedge+1; returns at posedge+1 after the transfer edge
    task automatic send(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b, input logic cin);
        bit done = 1'b0;
        in_a = a; in_b = b; in_cin = cin; in_val = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (in_rdy) done = 1'b1;
            @(posedge clk); #1;
        end
        in_val = 1'b0;
        in_a = NBITS'($urandom);
        in_b = NBITS'($urandom);
        in_cin = 1'($urandom_range(0, 1));
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: got in_rdy=0 expected in_rdy=1");
        end
    endtask

    // Returns at a falling edge where out_val is high, or flags a timeout
    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4 * NBITS && !ok; i++) begin
            @(negedge clk);
            if (out_val) ok = 1'b1;
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL out_timeout: got out_val=0 expected out_val=1");
        end
    endtask

    typedef struct {
        logic [NBITS-1:0] a;
        logic [NBITS-1:0] b;
        logic             cin;
        logic [NBITS-1:0] sum;
        logic             cout;
    } vec_t;

    function automatic vec_t mk(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b,
                                input logic cin, input logic [NBITS-1:0] sum, input logic cout);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin; v.sum = sum; v.cout = cout;
        return v;
    endfunction

    initial begin
        vec_t tbl[8];
        bit ok;
        int n0;
        int r0;
        logic [NBITS:0] tmp;

        tbl[0] = mk(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        tbl[1] = mk(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        tbl[2] = mk(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
        tbl[3] = mk(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
        tbl[4] = mk(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
        for (int i = 5; i < 8; i++) begin
            tbl[i].a   = NBITS'($urandom_range(0, 255));
            tbl[i].b   = NBITS'($urandom_range(0, 255));
            tbl[i].cin = 1'($urandom_range(0, 1));
            tmp = {1'b0, tbl[i].a} + {1'b0, tbl[i].b} + (NBITS+1)'(tbl[i].cin);
            tbl[i].sum  = tmp[NBITS-1:0];
            tbl[i].cout = tmp[NBITS];
        end

        // Reset state
        #1 reset = 1'b1;
        #2;
        check("rst_in_rdy", 64'(in_rdy), 64'(0));
        check("rst_out_val", 64'(out_val), 64'(0));
        check("rst_out_sum", 64'(out_sum), 64'(0));
        check("rst_out_cout", 64'(out_cout), 64'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("idle_in_rdy", 64'(in_rdy), 64'(1));
        check("idle_state", 64'(dbg_state), 64'(S_IDLE));
        @(posedge clk); #1;

        // Vector table with out_rdy already high
        out_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].cin);
            wait_out(ok);
            if (ok) begin
                check($sformatf("vec%0d_sum", i), 64'(out_sum), 64'(tbl[i].sum));
                check($sformatf("vec%0d_cout", i), 64'(out_cout), 64'(tbl[i].cout));
            end
            @(posedge clk); #1;
        end

        // Back-pressure: hold the result for 5 cycles
        out_rdy = 1'b0;
        send(8'h12, 8'h34, 1'b0);
        wait_out(ok);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("hold_out_val", 64'(out_val), 64'(1));
            check("hold_out_sum", 64'(out_sum), 64'(8'h46));
            check("hold_out_cout", 64'(out_cout), 64'(0));
            check("hold_in_rdy", 64'(in_rdy), 64'(0));
        end
        @(posedge clk); #1;
        n0 = n_out;
        out_rdy = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("hold_one_xfer", 64'(n_out - n0), 64'(1));
        check("hold_after_val", 64'(out_val), 64'(0));
        check("hold_after_rdy", 64'(in_rdy), 64'(1));
        @(posedge clk); #1;

        // Reset in the 3rd CALC cycle aborts the operation
        send(8'hF0, 8'h0F, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("abort_out_val", 64'(out_val), 64'(0));
        check("abort_in_rdy", 64'(in_rdy), 64'(0));
        check("abort_out_sum", 64'(out_sum), 64'(0));
        check("abort_state", 64'(dbg_state), 64'(S_IDLE));
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_rel_rdy", 64'(in_rdy), 64'(1));
        check("abort_rel_val", 64'(out_val), 64'(0));
        @(posedge clk); #1;
        send(8'h12, 8'h34, 1'b0);
        wait_out(ok);
        if (ok) check("abort_next_sum", 64'({out_cout, out_sum}), 64'(9'h046));
        @(posedge clk); #1;

        // Back-to-back with in_val and out_rdy high
        out_rdy = 1'b1;
        n0 = n_out;
        r0 = rise_edges.size();
        send(8'hC3, 8'h4E, 1'b1);
        send(8'h80, 8'h80, 1'b0);
        for (int i = 0; i < 8 * NBITS && n_out < n0 + 2; i++) @(posedge clk);
        #1;
        check("b2b_count", 64'(n_out - n0), 64'(2));
        if (rise_edges.size() >= r0 + 2)
            check("b2b_spacing", 64'(rise_edges[r0+1] - rise_edges[r0]), 64'(SPACING));
        else
            check("b2b_rises", 64'(rise_edges.size() - r0), 64'(2));
        repeat (2) @(posedge clk);
        #1;
        check("sb_drained", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
